reg_writeback: RTL and testbench

// - Owns the write side of the 32-entry register file: drives its single write port (writeEnC/writeC/writeDataC).
// - Arbitrates results from two producers, the ALU (direct path) and the load unit (buffered in a small FIFO).
// - Keeps a pending-write scoreboard so decode can stall on RAW hazards.
// - Sits between the execute/memory stages and the register file.

---
 rtl/reg_writeback_if.sv | 31 +++
 rtl/reg_writeback.sv | 91 +++++++++
 tb/tb_reg_writeback.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
// Write-back bus: ALU and load producer handshakes, issue marking, register-file
// write port, scoreboard and load-FIFO occupancy.
interface reg_writeback_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_rd;
    logic [XLEN-1:0]        alu_data;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [ADDR_W-1:0]      ld_rd;
    logic [XLEN-1:0]        ld_data;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_rd;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [2**ADDR_W-1:0]   pending;
    logic [ADDR_W:0]        ld_count;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending, ld_count
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        output alu_ready, ld_ready, wr_en, wr_addr, wr_data, pending, ld_count
    );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write side: ALU/load arbitration with a load FIFO, one registered
// commit per cycle, and a pending-write scoreboard for RAW stalls.
module reg_writeback #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int LD_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    reg_writeback_if.slave bus
);
    localparam int PW   = $clog2(LD_DEPTH);
    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(LD_DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } ld_ent_t;

    ld_ent_t           fifo_q [LD_DEPTH];
    logic [PW-1:0]     rptr_q, wptr_q;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic              fifo_full, fifo_empty, fifo_win, push, commit;
    logic [ADDR_W-1:0] commit_rd;
    logic [XLEN-1:0]   commit_data;

    assign fifo_full  = (cnt_q == CNT_FULL);
    assign fifo_empty = (cnt_q == '0);
    // A full FIFO must drain even while the ALU keeps offering, or loads would stall forever.
    assign fifo_win   = !fifo_empty && (fifo_full || !bus.alu_valid);
    assign push       = bus.ld_valid && !fifo_full;
    assign commit     = fifo_win || bus.alu_valid;

    assign bus.alu_ready = bus.alu_valid && !fifo_win;
    assign bus.ld_ready  = !fifo_full;
    assign bus.ld_count  = cnt_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.pending   = pending_q;

    always_comb begin
        commit_rd   = fifo_win ? fifo_q[rptr_q].rd   : bus.alu_rd;
        commit_data = fifo_win ? fifo_q[rptr_q].data : bus.alu_data;

        cnt_d = cnt_q;
        if (push && !fifo_win)      cnt_d = cnt_q + CNT_ONE;
        else if (!push && fifo_win) cnt_d = cnt_q - CNT_ONE;

        // x0 commits are consumed but never reach the register file.
        wr_en_d   = commit && (commit_rd != '0);
        wr_addr_d = wr_en_d ? commit_rd   : wr_addr_q;
        wr_data_d = wr_en_d ? commit_data : wr_data_q;

        pending_d = pending_q;
        if (commit) pending_d[commit_rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) pending_d[bus.issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= '{rd: bus.ld_rd, data: bus.ld_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q    <= '0;
            wptr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            rptr_q    <= rptr_q + PW'(fifo_win);
            wptr_q    <= wptr_q + PW'(push);
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: hand-computed vector table, async reset sequence and
// randomized traffic against a queue-based reference model.
module tb_reg_writeback;
    logic clk, reset;
    int checks = 0, failures = 0;

    reg_writeback_if #(.XLEN(32), .ADDR_W(5)) bus ();
    reg_writeback #(.XLEN(32), .ADDR_W(5), .LD_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: load queue, expected write-port state, pending bit vector.
    typedef struct { logic [4:0] rd; logic [31:0] d; } ld_t;
    ld_t         mq[$];
    logic        m_wen;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_pend;
    bit          m_amb;
    bit          m_alu_acc;

    task automatic model_reset();
        mq.delete();
        m_wen = 0; m_wa = 0; m_wd = 0; m_pend = 0; m_amb = 0; m_alu_acc = 0;
    endtask

    function automatic bit fifo_wins();
        return mq.size() > 0 && (mq.size() == 4 || !bus.alu_valid);
    endfunction

    task automatic model_check();
        chk("alu_ready", bus.alu_ready, bus.alu_valid && !fifo_wins());
        chk("ld_ready", bus.ld_ready, mq.size() != 4);
        chk("ld_count", bus.ld_count, mq.size());
        chk("wr_en", bus.wr_en, m_wen);
        if (m_wen || !m_amb) begin
            chk("wr_addr", bus.wr_addr, m_wa);
            chk("wr_data", bus.wr_data, m_wd);
        end
        chk("pending", bus.pending, m_pend);
    endtask

    task automatic model_edge();
        bit fw, com;
        ld_t e;
        fw  = fifo_wins();
        com = 0;
        m_alu_acc = 0;
        e.rd = 0; e.d = 0;
        if (fw) begin
            e = mq.pop_front(); com = 1;
        end else if (bus.alu_valid) begin
            e.rd = bus.alu_rd; e.d = bus.alu_data; com = 1; m_alu_acc = 1;
        end
        if (bus.ld_valid && (mq.size() + (fw ? 1 : 0)) != 4) begin
            ld_t n; n.rd = bus.ld_rd; n.d = bus.ld_data; mq.push_back(n);
        end
        if (com) m_pend[e.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != 0) m_pend[bus.issue_rd] = 1'b1;
        m_wen = com && e.rd != 0;
        if (m_wen) begin m_wa = e.rd; m_wd = e.d; m_amb = 0; end
        else if (com) m_amb = 1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                         input logic iv, input logic [4:0] ird);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.ld_valid = lv;  bus.ld_rd = lrd;  bus.ld_data = ldd;
        bus.issue_valid = iv; bus.issue_rd = ird;
    endtask

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic lv; logic [4:0] lrd; logic [31:0] ldd;
        logic iv; logic [4:0] ird;
        logic e_ar, e_lr, e_wen, chk_wd;
        logic [4:0] e_wa; logic [31:0] e_wd; int e_cnt; logic [31:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                                input logic iv, input logic [4:0] ird,
                                input logic e_ar, input logic e_lr, input logic e_wen,
                                input logic chk_wd, input logic [4:0] e_wa, input logic [31:0] e_wd,
                                input int e_cnt, input logic [31:0] e_pend);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ldd = ldd;
        v.iv = iv; v.ird = ird; v.e_ar = e_ar; v.e_lr = e_lr; v.e_wen = e_wen;
        v.chk_wd = chk_wd; v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt; v.e_pend = e_pend;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // row fields: alu(v,rd,data) ld(v,rd,data) issue(v,rd) | ar lr wen chkwd wa wd cnt pend
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 5,  0, 1, 0, 0, 0, 0,     0, 32'h20));
        tbl.push_back(mk(1, 5, 'hAC,  0, 0, 0,     0, 0,  1, 1, 1, 0, 5, 'hAC,  0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 0, 1, 5, 'hAC,  0, 0));
        tbl.push_back(mk(0, 0, 0,     1, 3, 'h11,  0, 0,  0, 1, 0, 0, 0, 0,     1, 0));
        tbl.push_back(mk(1, 6, 'h33,  1, 4, 'h22,  0, 0,  1, 1, 1, 0, 6, 'h33,  2, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 1, 0, 3, 'h11,  1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 1, 0, 4, 'h22,  0, 0));
        tbl.push_back(mk(1, 9, 'h99,  1, 8, 'hA0,  0, 0,  1, 1, 1, 0, 9, 'h99,  1, 0));
        tbl.push_back(mk(1, 11, 'hB1, 1, 10, 'hA1, 0, 0,  1, 1, 1, 0, 11, 'hB1, 2, 0));
        tbl.push_back(mk(1, 13, 'hB2, 1, 12, 'hA2, 0, 0,  1, 1, 1, 0, 13, 'hB2, 3, 0));
        tbl.push_back(mk(1, 15, 'hB3, 1, 14, 'hA3, 0, 0,  1, 1, 1, 0, 15, 'hB3, 4, 0));
        tbl.push_back(mk(1, 17, 'hB4, 1, 16, 'hA4, 0, 0,  0, 0, 1, 0, 8, 'hA0,  3, 0));
        tbl.push_back(mk(1, 17, 'hB4, 1, 16, 'hA4, 0, 0,  1, 1, 1, 0, 17, 'hB4, 4, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 0, 1, 0, 10, 'hA1, 3, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 1, 0, 12, 'hA2, 2, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 1, 0, 14, 'hA3, 1, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0,  0, 1, 1, 0, 16, 'hA4, 0, 0));
        tbl.push_back(mk(1, 0, 'h98,  0, 0, 0,     1, 0,  1, 1, 0, 0, 0, 0,     0, 0));
        tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 7,  0, 1, 0, 0, 0, 0,     0, 32'h80));
        tbl.push_back(mk(1, 7, 'h77,  0, 0, 0,     1, 7,  1, 1, 1, 0, 7, 'h77,  0, 32'h80));
        tbl.push_back(mk(1, 7, 'h78,  0, 0, 0,     0, 0,  1, 1, 1, 0, 7, 'h78,  0, 0));

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        #3;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_ld_count", bus.ld_count, 0);
        #9 reset = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ldd,
                  tbl[i].iv, tbl[i].ird);
            @(negedge clk);
            model_check();
            chk($sformatf("v%0d_alu_ready", i), bus.alu_ready, tbl[i].e_ar);
            chk($sformatf("v%0d_ld_ready", i), bus.ld_ready, tbl[i].e_lr);
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("v%0d_wr_en", i), bus.wr_en, tbl[i].e_wen);
            if (tbl[i].e_wen || tbl[i].chk_wd) begin
                chk($sformatf("v%0d_wr_addr", i), bus.wr_addr, tbl[i].e_wa);
                chk($sformatf("v%0d_wr_data", i), bus.wr_data, tbl[i].e_wd);
            end
            chk($sformatf("v%0d_ld_count", i), bus.ld_count, tbl[i].e_cnt);
            chk($sformatf("v%0d_pending", i), bus.pending, tbl[i].e_pend);
        end

        // Build up buffered loads and pending bits, then reset mid-cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(20 + k), 32'h500 + k, 1, 5'(24 + k), 32'h600 + k, 1, 5'(9 + k));
            @(negedge clk); model_check();
            @(posedge clk); model_edge(); #1;
        end
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_ld_count", bus.ld_count, 0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); model_check();
            chk("post_rst_no_write", bus.wr_en, 0);
            @(posedge clk); model_edge(); #1;
        end

        // Random traffic; the ALU producer holds its offer until accepted.
        for (int c = 0; c < 3000; c++) begin
            if (!(bus.alu_valid && !m_alu_acc)) begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_rd    = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            bus.ld_valid    = ($urandom_range(0, 1) != 0);
            bus.ld_rd       = 5'($urandom_range(0, 7));
            bus.ld_data     = $urandom;
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd    = 5'($urandom_range(0, 7));
            @(negedge clk); model_check();
            @(posedge clk); model_edge(); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
